// File: rtl/vend_pkg.sv
// Shared vending definitions: coin values and the change payout state encoding.
package vend_pkg;

    localparam logic [3:0] COIN_1  = 4'd1;
    localparam logic [3:0] COIN_5  = 4'd5;
    localparam logic [3:0] COIN_10 = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_EJECT  = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAULT  = 3'd4
    } payout_state_t;

endpackage

// File: rtl/coin_selector.sv
// Greedy coin choice: the largest stocked denomination not exceeding the remaining change.
module coin_selector
    import vend_pkg::*;
#(
    parameter int INV_W = 4
) (
    input  logic [4:0]       remaining,
    input  logic [INV_W-1:0] inv_1,
    input  logic [INV_W-1:0] inv_5,
    input  logic [INV_W-1:0] inv_10,
    output logic [3:0]       coin,
    output logic             none_avail
);

    always_comb begin
        coin       = 4'd0;
        none_avail = 1'b0;
        if (remaining >= 5'(COIN_10) && inv_10 != '0)
            coin = COIN_10;
        else if (remaining >= 5'(COIN_5) && inv_5 != '0)
            coin = COIN_5;
        else if (remaining >= 5'(COIN_1) && inv_1 != '0)
            coin = COIN_1;
        else
            none_avail = 1'b1;
    end

endmodule

// File: rtl/change_payout_ctrl.sv
// Change payout sequencer: ejects coins one at a time over a valid/ack handshake,
// tracking per-denomination inventory and flagging shortfall and hopper jams.
module change_payout_ctrl
    import vend_pkg::*;
#(
    parameter int INV_W       = 4,
    parameter int INIT_COUNT  = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       amount,
    output logic             eject_valid,
    output logic [3:0]       eject_coin,
    input  logic             eject_ack,
    input  logic             refill,
    input  logic [1:0]       refill_sel,
    input  logic [INV_W-1:0] refill_cnt,
    input  logic             fault_clr,
    output logic             busy,
    output logic             done,
    output logic             shortfall,
    output logic [4:0]       owed,
    output logic             jam,
    output logic [INV_W-1:0] inv_1,
    output logic [INV_W-1:0] inv_5,
    output logic [INV_W-1:0] inv_10
);

    localparam int                 TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [INV_W-1:0]   INV_INIT = INV_W'(INIT_COUNT);
    localparam logic [INV_W-1:0]   INV_ONE  = INV_W'(1);

    payout_state_t    state;
    logic [4:0]       remaining;
    logic [TMO_W-1:0] tmo_cnt;
    logic [3:0]       sel_coin;
    logic             none_avail;

    coin_selector #(.INV_W(INV_W)) u_coin_selector (
        .remaining  (remaining),
        .inv_1      (inv_1),
        .inv_5      (inv_5),
        .inv_10     (inv_10),
        .coin       (sel_coin),
        .none_avail (none_avail)
    );

    function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                                 input logic [INV_W-1:0] b);
        logic [INV_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[INV_W] ? '1 : s[INV_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            tmo_cnt     <= '0;
            eject_valid <= 1'b0;
            eject_coin  <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            shortfall   <= 1'b0;
            owed        <= '0;
            jam         <= 1'b0;
            inv_1       <= INV_INIT;
            inv_5       <= INV_INIT;
            inv_10      <= INV_INIT;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    // Refill lands on this edge so the first SELECT already sees it.
                    if (refill) begin
                        case (refill_sel)
                            2'd0:    inv_1  <= sat_add(inv_1,  refill_cnt);
                            2'd1:    inv_5  <= sat_add(inv_5,  refill_cnt);
                            2'd2:    inv_10 <= sat_add(inv_10, refill_cnt);
                            default: ;
                        endcase
                    end
                    if (start) begin
                        remaining <= amount;
                        shortfall <= 1'b0;
                        owed      <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (remaining == '0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (none_avail) begin
                        shortfall <= 1'b1;
                        owed      <= remaining;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        eject_coin  <= sel_coin;
                        eject_valid <= 1'b1;
                        state       <= ST_EJECT;
                    end
                end
                ST_EJECT: begin
                    if (eject_ack) begin
                        remaining   <= remaining - 5'(eject_coin);
                        tmo_cnt     <= '0;
                        eject_valid <= 1'b0;
                        eject_coin  <= 4'd0;
                        state       <= ST_SELECT;
                        case (eject_coin)
                            COIN_1:  inv_1  <= inv_1  - INV_ONE;
                            COIN_5:  inv_5  <= inv_5  - INV_ONE;
                            COIN_10: inv_10 <= inv_10 - INV_ONE;
                            default: ;
                        endcase
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Hopper stopped responding: freeze and report what is still owed.
                        owed        <= remaining;
                        tmo_cnt     <= '0;
                        eject_valid <= 1'b0;
                        eject_coin  <= 4'd0;
                        jam         <= 1'b1;
                        state       <= ST_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        jam   <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/change_payout_ctrl.md
# change_payout_ctrl

Sequencer that pays out change after a vend: takes the change amount produced by the vending controller on its dispense cycle and drives the coin hopper one coin at a time over a valid/ack handshake. It selects coins greedily (10, then 5, then 1) and tracks per-denomination hopper inventory. It reports shortfall when inventory cannot cover the amount, and enters a jam fault when the hopper stops acknowledging. It sits between the vending FSM (`dispense`/`change`) and the physical hopper driver.

## Interface
Parameters:
- `INV_W`, 4: width of each inventory counter; saturates at 2^INV_W−1.
- `INIT_COUNT`, 8: inventory value of each denomination after reset.
- `ACK_TIMEOUT`, 15: cycles `eject_valid` may stay high without `eject_ack` before jam fault.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: payout request. Sampled only in IDLE.
- `amount`, in, 5: change to pay, 0..31. Captured when `start` is accepted.
- `eject_valid`, out, 1: coin eject request to the hopper.
- `eject_coin`, out, 4: denomination to eject, one of 1, 5 or 10. 0 when idle.
- `eject_ack`, in, 1: hopper accepted the coin. Only meaningful while `eject_valid`=1.
- `refill`, in, 1: add coins to inventory. Honoured only in IDLE.
- `refill_sel`, in, 2: denomination to refill. 0 selects 1, 1 selects 5, 2 selects 10, 3 is ignored.
- `refill_cnt`, in, INV_W: number of coins to add.
- `fault_clr`, in, 1: leave FAULT and return to IDLE.
- `busy`, out, 1: high whenever state is not IDLE.
- `done`, out, 1: one-cycle pulse when a payout completes.
- `shortfall`, out, 1: the last payout could not be completed from inventory.
- `owed`, out, 5: amount left unpaid by the last payout or jam.
- `jam`, out, 1: high while in FAULT.
- `inv_1`, `inv_5`, `inv_10`, out, INV_W each: current inventory.

## Operation
States:
- **IDLE**
  - `start`=1: latch `amount` into `remaining`, clear `shortfall` and `owed`, go to SELECT.
  - `start` while not in IDLE is ignored; it is neither queued nor latched.
- **SELECT**
  - `remaining`=0: go to DONE with `shortfall`=0.
  - Otherwise pick the largest denomination d with d ≤ `remaining` and inventory(d) > 0, drive `eject_coin`=d and go to EJECT.
  - No such d: `shortfall`=1, `owed`=`remaining`, go to DONE.
- **EJECT**
  - `eject_valid`=1, with `eject_coin` held stable until acknowledged.
  - On a sampled `eject_ack`: `remaining` −= d, inventory(d) −= 1, reset the timeout counter, go to SELECT.
  - Without an ack the timeout counter increments. When it reaches ACK_TIMEOUT: `owed`=`remaining`, go to FAULT.
- **DONE**: `done`=1 for exactly this cycle, then go to IDLE.
- **FAULT**
  - `jam`=1 and `busy`=1; inventory is frozen.
  - `fault_clr`=1: go to IDLE. `jam` clears; `owed` is retained.

Rules:
- Greedy selection is exact for the {1,5,10} coin set; no backtracking.
- `remaining` is 5 bits and never underflows, because d ≤ `remaining` is guaranteed at selection.
- Refill adds `refill_cnt` to the selected counter, saturating at all-ones. A refill outside IDLE is dropped.
- If `refill` and `start` arrive in the same IDLE cycle, both take effect. The refilled count is visible to the first SELECT.
- `eject_ack` outside EJECT is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `eject_valid`=0, `eject_coin`=0, `busy`=0, `done`=0, `shortfall`=0, `owed`=0, `jam`=0.
  - `inv_*`=INIT_COUNT, timeout counter 0.
- Reset mid-payout aborts immediately. No `done` pulse follows, and inventory returns to INIT_COUNT.
- All outputs are registered.
- Latency:
  - From the `start` edge: SELECT in cycle 1, `eject_valid` first high in cycle 2.
  - An ack sampled with `eject_valid` takes 1 cycle to SELECT, so the next `eject_valid` is 2 cycles later. Minimum throughput is 1 coin per 2 cycles.
  - `amount`=0: `done` pulses 2 cycles after `start`.
  - Shortfall is detected in SELECT; `done` and `shortfall` are visible the cycle after.

## Structure
- Shared package `vend_pkg`:
  - Coin value constants `COIN_1`, `COIN_5`, `COIN_10` (shared with the vending controller's valid-coin check).
  - The payout state enum.
- Sub-module `coin_selector` (combinational): takes `remaining` and the three inventory counts, and returns the chosen denomination plus a `none_avail` flag.
- Timeout counter and inventory counters stay in the top module.

## Test plan
- Full inventory, `amount`=16, ack same cycle as each valid → ejects 10, 5, 1 in order; `done` 1 cycle after the last SELECT; inventory 7/7/7; `shortfall`=0.
- `amount`=0 → no `eject_valid`; `done` pulses at cycle 2.
- `inv_10` refilled to 0 beforehand is not possible, so use `rst` with INIT_COUNT=8, drain `inv_10` by payouts, then `amount`=20 → four 5-coin ejects.
- `inv_1`=0, `amount`=3 → no ejects; `shortfall`=1, `owed`=3.
- `amount`=7, `eject_ack` withheld → `jam` after 15 cycles of `eject_valid`, `owed`=7; `fault_clr` → IDLE with `busy`=0.
- Second `start` mid-payout is ignored. `rst` asserted during EJECT → all reset values next cycle.
- `refill` of `refill_cnt`=15 onto a count of 8 → saturates at 15. The same refill while busy → no change.
